// File: rtl/ps2_button_mapper_if.sv
// Keycode table write port for ps2_button_mapper.
//   master : drives table writes (host / hps side)
//   slave  : ps2_button_mapper
// Ports:
//   map_we   - one-cycle write strobe
//   map_addr - table index
//   map_data - {valid, ext_wild, code[8:0], btn_idx}
interface ps2_button_mapper_if #(
   parameter int NUM_BTN   = 8,
   parameter int MAP_DEPTH = 32
);
   localparam int AW = $clog2(MAP_DEPTH);
   localparam int BW = $clog2(NUM_BTN);

   logic              map_we;
   logic [AW-1:0]     map_addr;
   logic [11+BW-1:0]  map_data;

   modport master (output map_we, map_addr, map_data);
   modport slave  (input  map_we, map_addr, map_data);
endinterface

// File: rtl/ps2_button_mapper.sv
// Maps ps2_key toggle events and joystick bits onto active-low cabinet
// buttons through a runtime-writable keycode table scanned one entry per
// cycle. Provides per-button minimum-pulse stretching, a one-deep pending
// event buffer and a global keyboard release.
// Ports:
//   clk, rst_l    - core clock, async active-low reset
//   ps2_key       - [10] toggle, [9] pressed, [8:0] {ext, scancode}
//   joy           - joystick bits, active-high
//   joy_idx       - joystick bit index per button (slice b = button b)
//   joy_en        - per-button joystick enable
//   stretch_mask  - buttons that get minimum-pulse stretching
//   map_bus       - keycode table write port
//   clear_all     - drop all keyboard state, abort scan, drop pending event
//   btn_n         - button outputs, active-low, registered
//   btn_press     - one-cycle pulse on each 1->0 of btn_n
//   busy          - table scan in progress
//   overflow      - sticky, an event was dropped
//
// state | meaning
// ARM   | first cycle after reset, samples toggle without raising an event
// IDLE  | waiting for a ps2_key event
// SCAN  | walking table entries idx = 0 .. MAP_DEPTH-1 for event ev_q
module ps2_button_mapper #(
   parameter int NUM_BTN        = 8,
   parameter int MAP_DEPTH      = 32,
   parameter int JOY_W          = 16,
   parameter int STRETCH_CYCLES = 65535
) (
   input  logic                            clk,
   input  logic                            rst_l,
   input  logic [10:0]                     ps2_key,
   input  logic [JOY_W-1:0]                joy,
   input  logic [NUM_BTN*$clog2(JOY_W)-1:0] joy_idx,
   input  logic [NUM_BTN-1:0]              joy_en,
   input  logic [NUM_BTN-1:0]              stretch_mask,
   ps2_button_mapper_if.slave              map_bus,
   input  logic                            clear_all,
   output logic [NUM_BTN-1:0]              btn_n,
   output logic [NUM_BTN-1:0]              btn_press,
   output logic                            busy,
   output logic                            overflow
);
   localparam int AW = $clog2(MAP_DEPTH);
   localparam int BW = $clog2(NUM_BTN);
   localparam int JW = $clog2(JOY_W);
   localparam int CW = $clog2(STRETCH_CYCLES + 1);

   typedef enum logic [1:0] {ST_ARM, ST_IDLE, ST_SCAN} state_t;

   state_t               state;
   logic                 tog_q;
   logic [AW-1:0]        idx;
   logic [9:0]           ev_q;
   logic [9:0]           pend_q;
   logic                 pend_vld;
   logic [NUM_BTN-1:0]   key_state;

   logic [MAP_DEPTH-1:0] tbl_valid;
   logic [MAP_DEPTH-1:0] tbl_wild;
   logic [8:0]           tbl_code [MAP_DEPTH];
   logic [BW-1:0]        tbl_btn  [MAP_DEPTH];

   logic [NUM_BTN-1:0]   raw;
   logic [NUM_BTN-1:0]   raw_q;
   logic [NUM_BTN-1:0]   active;
   logic [CW-1:0]        cnt [NUM_BTN];

   logic ev_det;
   logic hit;
   logic btn_ok;
   logic last;

   // Only valid bits need a reset; the payload is don't-care until valid.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l)
         tbl_valid <= '0;
      else if (map_bus.map_we)
         tbl_valid[map_bus.map_addr] <= map_bus.map_data[10+BW];
   end

   always_ff @(posedge clk) begin
      if (map_bus.map_we) begin
         tbl_wild[map_bus.map_addr] <= map_bus.map_data[9+BW];
         tbl_code[map_bus.map_addr] <= map_bus.map_data[8+BW:BW];
         tbl_btn[map_bus.map_addr]  <= map_bus.map_data[BW-1:0];
      end
   end

   assign ev_det = (state != ST_ARM) && (ps2_key[10] != tog_q);
   assign hit    = tbl_valid[idx] && (tbl_code[idx][7:0] == ev_q[7:0]) &&
                   (tbl_wild[idx] || (tbl_code[idx][8] == ev_q[8]));
   // Extra bit keeps the compare meaningful when NUM_BTN is a power of 2.
   assign btn_ok = {1'b0, tbl_btn[idx]} < (BW+1)'(NUM_BTN);
   assign last   = (idx == AW'(MAP_DEPTH - 1));

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state     <= ST_ARM;
         tog_q     <= 1'b0;
         idx       <= '0;
         ev_q      <= '0;
         pend_q    <= '0;
         pend_vld  <= 1'b0;
         key_state <= '0;
         busy      <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         tog_q <= ps2_key[10];
         if (clear_all) begin
            key_state <= '0;
            pend_vld  <= 1'b0;
            idx       <= '0;
            state     <= ST_IDLE;
            busy      <= 1'b0;
         end else begin
            case (state)
               ST_ARM: state <= ST_IDLE;
               ST_IDLE: begin
                  if (ev_det) begin
                     ev_q  <= ps2_key[9:0];
                     idx   <= '0;
                     state <= ST_SCAN;
                     busy  <= 1'b1;
                  end
               end
               ST_SCAN: begin
                  if (hit && btn_ok)
                     key_state[tbl_btn[idx]] <= ev_q[9];
                  if (last) begin
                     idx <= '0;
                     // An event landing on the final cycle is not lost:
                     // it either becomes the next scan or refills pending.
                     if (pend_vld) begin
                        ev_q     <= pend_q;
                        pend_vld <= ev_det;
                        if (ev_det)
                           pend_q <= ps2_key[9:0];
                     end else if (ev_det) begin
                        ev_q <= ps2_key[9:0];
                     end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                     end
                  end else begin
                     idx <= idx + 1'b1;
                     if (ev_det) begin
                        if (pend_vld) begin
                           overflow <= 1'b1;
                        end else begin
                           pend_q   <= ps2_key[9:0];
                           pend_vld <= 1'b1;
                        end
                     end
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   always_comb begin
      raw    = '0;
      active = '0;
      for (int b = 0; b < NUM_BTN; b++) begin
         raw[b]    = key_state[b] | (joy_en[b] & joy[joy_idx[b*JW +: JW]]);
         active[b] = raw[b] | (cnt[b] != '0);
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         raw_q     <= '0;
         btn_n     <= '1;
         btn_press <= '0;
         for (int b = 0; b < NUM_BTN; b++)
            cnt[b] <= '0;
      end else begin
         raw_q     <= raw;
         btn_n     <= ~active;
         btn_press <= btn_n & active;
         for (int b = 0; b < NUM_BTN; b++) begin
            if (clear_all)
               cnt[b] <= '0;
            else if (stretch_mask[b] && raw[b] && !raw_q[b])
               cnt[b] <= CW'(STRETCH_CYCLES);
            else if (cnt[b] != '0)
               cnt[b] <= cnt[b] - 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_ps2_button_mapper.sv
module tb_ps2_button_mapper;
   localparam int NB  = 8;
   localparam int MD  = 32;
   localparam int JW  = 16;
   localparam int SC  = 100;
   localparam int JIW = 4;
   localparam int BW  = 3;

   logic              clk = 1'b0;
   logic              rst_l = 1'b0;
   logic [10:0]       ps2_key = '0;
   logic [JW-1:0]     joy = '0;
   logic [NB*JIW-1:0] joy_idx = '0;
   logic [NB-1:0]     joy_en = '0;
   logic [NB-1:0]     stretch_mask = '0;
   logic              clear_all = 1'b0;
   logic [NB-1:0]     btn_n;
   logic [NB-1:0]     btn_press;
   logic              busy;
   logic              overflow;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: table contents and per-button keyboard state
   logic          m_valid [MD];
   logic          m_wild  [MD];
   logic [8:0]    m_code  [MD];
   int            m_btn   [MD];
   logic [NB-1:0] m_ks;
   logic [8:0]    pool [6];

   always #5 clk = ~clk;

   ps2_button_mapper_if #(.NUM_BTN(NB), .MAP_DEPTH(MD)) mbus ();

   ps2_button_mapper #(
      .NUM_BTN(NB), .MAP_DEPTH(MD), .JOY_W(JW), .STRETCH_CYCLES(SC)
   ) dut (
      .clk(clk), .rst_l(rst_l), .ps2_key(ps2_key), .joy(joy),
      .joy_idx(joy_idx), .joy_en(joy_en), .stretch_mask(stretch_mask),
      .map_bus(mbus), .clear_all(clear_all), .btn_n(btn_n),
      .btn_press(btn_press), .busy(busy), .overflow(overflow)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void model_clear_table();
      for (int i = 0; i < MD; i++) begin
         m_valid[i] = 1'b0;
         m_wild[i]  = 1'b0;
         m_code[i]  = '0;
         m_btn[i]   = 0;
      end
      m_ks = '0;
   endfunction

   // A key event sets every mapped button it matches, later entries winning.
   function automatic void model_apply(input logic p, input logic [8:0] c);
      for (int i = 0; i < MD; i++)
         if (m_valid[i] && m_code[i][7:0] == c[7:0] && (m_wild[i] || m_code[i][8] == c[8]))
            if (m_btn[i] < NB)
               m_ks[m_btn[i]] = p;
   endfunction

   function automatic logic [NB-1:0] exp_btn_n();
      logic [NB-1:0] r;
      r = m_ks;
      for (int b = 0; b < NB; b++)
         if (joy_en[b] && joy[joy_idx[b*JIW +: JIW]])
            r[b] = 1'b1;
      return ~r;
   endfunction

   task automatic write_entry(input int a, input logic v, input logic w,
                              input logic [8:0] c, input int b);
      mbus.map_we   = 1'b1;
      mbus.map_addr = a[4:0];
      mbus.map_data = {v, w, c, b[BW-1:0]};
      tick;
      mbus.map_we = 1'b0;
      m_valid[a] = v;
      m_wild[a]  = w;
      m_code[a]  = c;
      m_btn[a]   = b;
   endtask

   task automatic send_key(input logic p, input logic [8:0] c);
      ps2_key = {~ps2_key[10], p, c};
   endtask

   task automatic wait_idle;
      int n;
      n = 0;
      tick;
      while (busy === 1'b1 && n < 300) begin
         tick;
         n++;
      end
      check("scan_done", 32'(busy), 0);
      tick;
      tick;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      int lows;
      int presses;
      int nev;
      logic p;
      logic [8:0] c;

      pool = '{9'h01C, 9'h11C, 9'h03A, 9'h13A, 9'h06B, 9'h16B};
      mbus.map_we   = 1'b0;
      mbus.map_addr = '0;
      mbus.map_data = '0;
      model_clear_table();

      // reset values
      tick;
      tick;
      check("rst_btn_n", 32'(btn_n), 32'hFF);
      check("rst_press", 32'(btn_press), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_ovf", 32'(overflow), 0);
      rst_l = 1'b1;
      tick;
      tick;

      // empty table: scan runs exactly MAP_DEPTH cycles, no button moves
      send_key(1'b1, 9'h03A);
      model_apply(1'b1, 9'h03A);
      n = 0;
      tick;
      while (busy === 1'b1 && n < 100) begin
         n++;
         tick;
      end
      check("busy_len", 32'(n), MD);
      tick;
      tick;
      check("empty_btn_n", 32'(btn_n), 32'hFF);
      check("empty_ovf", 32'(overflow), 0);

      // entry 0 match: btn_n[4] drops two cycles after idx 0 is scanned
      write_entry(0, 1'b1, 1'b0, 9'h03A, 4);
      send_key(1'b1, 9'h03A);
      model_apply(1'b1, 9'h03A);
      tick;
      check("lat_c0", 32'(btn_n[4]), 1);
      tick;
      check("lat_c1", 32'(btn_n[4]), 1);
      tick;
      check("lat_c2", 32'(btn_n[4]), 0);
      check("press_pulse", 32'(btn_press), 32'h10);
      presses = 0;
      n = 0;
      tick;
      while (busy === 1'b1 && n < 100) begin
         if (btn_press[4]) presses++;
         tick;
         n++;
      end
      check("press_once", 32'(presses), 0);
      check("press_btn_n", 32'(btn_n), 32'(exp_btn_n()));
      send_key(1'b0, 9'h03A);
      model_apply(1'b0, 9'h03A);
      wait_idle;
      check("release_btn4", 32'(btn_n[4]), 1);

      // ext wildcard matches both extended and plain codes
      write_entry(5, 1'b1, 1'b1, 9'h06B, 6);
      send_key(1'b1, 9'h16B);
      model_apply(1'b1, 9'h16B);
      wait_idle;
      check("wild_press", 32'(btn_n[6]), 0);
      check("wild_press_all", 32'(btn_n), 32'(exp_btn_n()));
      send_key(1'b0, 9'h06B);
      model_apply(1'b0, 9'h06B);
      wait_idle;
      check("wild_release", 32'(btn_n[6]), 1);

      // clear_all mid-scan wins over a same-cycle event
      write_entry(7, 1'b1, 1'b0, 9'h01C, 1);
      send_key(1'b1, 9'h01C);
      model_apply(1'b1, 9'h01C);
      wait_idle;
      check("held_btn1", 32'(btn_n[1]), 0);
      send_key(1'b1, 9'h03A);
      repeat (5) tick;
      check("clr_midscan", 32'(busy), 1);
      clear_all = 1'b1;
      send_key(1'b1, 9'h16B);
      tick;
      clear_all = 1'b0;
      m_ks = '0;
      check("clr_busy", 32'(busy), 0);
      tick;
      check("clr_btn1", 32'(btn_n[1]), 1);
      check("clr_btn_n", 32'(btn_n), 32'hFF);
      check("clr_ovf", 32'(overflow), 0);
      repeat (40) tick;
      check("clr_no_scan", 32'(busy), 0);
      check("clr_discard", 32'(btn_n), 32'(exp_btn_n()));

      // joystick to btn_n in one cycle, no stretch when unmasked
      joy_en  = 8'h08;
      joy_idx[3*JIW +: JIW] = 4'd2;
      joy[2] = 1'b1;
      tick;
      check("joy_lat", 32'(btn_n[3]), 0);
      joy[2] = 1'b0;
      tick;
      check("joy_nostretch", 32'(btn_n[3]), 1);

      // stretch: 3-cycle joystick pulse held low for STRETCH_CYCLES+1
      stretch_mask = 8'h04;
      joy_en = 8'h04;
      joy_idx[2*JIW +: JIW] = 4'd7;
      tick;
      check("stretch_pre", 32'(btn_n[2]), 1);
      joy[7] = 1'b1;
      lows = 0;
      presses = 0;
      for (int i = 0; i < 150; i++) begin
         tick;
         if (!btn_n[2]) lows++;
         if (btn_press[2]) presses++;
         if (i == 2) joy[7] = 1'b0;
      end
      check("stretch_len", 32'(lows), SC + 1);
      check("stretch_press", 32'(presses), 1);
      stretch_mask = '0;
      joy_en = '0;

      // three events back to back: two applied in order, third dropped
      send_key(1'b1, 9'h03A);
      tick;
      send_key(1'b0, 9'h03A);
      tick;
      send_key(1'b1, 9'h16B);
      model_apply(1'b1, 9'h03A);
      model_apply(1'b0, 9'h03A);
      wait_idle;
      check("ovf_set", 32'(overflow), 1);
      check("ovf_order", 32'(btn_n[4]), 1);
      check("ovf_dropped", 32'(btn_n[6]), 1);
      check("ovf_btn_n", 32'(btn_n), 32'(exp_btn_n()));
      send_key(1'b1, 9'h01C);
      model_apply(1'b1, 9'h01C);
      wait_idle;
      check("ovf_sticky", 32'(overflow), 1);
      check("after_ovf_btn1", 32'(btn_n[1]), 0);

      // async reset mid-scan releases outputs without a clock
      send_key(1'b1, 9'h03A);
      repeat (4) tick;
      check("arst_pre_busy", 32'(busy), 1);
      check("arst_pre_btn", 32'(btn_n[4]), 0);
      rst_l = 1'b0;
      #1;
      check("arst_btn_n", 32'(btn_n), 32'hFF);
      check("arst_busy", 32'(busy), 0);
      check("arst_ovf", 32'(overflow), 0);
      tick;
      rst_l = 1'b1;
      model_clear_table();
      tick;
      tick;

      // randomized table, joystick and event bursts against the model
      for (int i = 0; i < MD; i++)
         write_entry(i, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                     pool[$urandom_range(0, 5)], int'($urandom_range(0, NB - 1)));
      for (int it = 0; it < 40; it++) begin
         write_entry(int'($urandom_range(0, MD - 1)), 1'b1, 1'($urandom_range(0, 1)),
                     pool[$urandom_range(0, 5)], int'($urandom_range(0, NB - 1)));
         joy     = 16'($urandom);
         joy_en  = 8'($urandom);
         joy_idx = $urandom;
         nev = int'($urandom_range(1, 2));
         for (int e = 0; e < nev; e++) begin
            p = 1'($urandom_range(0, 1));
            c = pool[$urandom_range(0, 5)];
            send_key(p, c);
            model_apply(p, c);
            if (e == 0 && nev == 2) tick;
         end
         wait_idle;
         check("rand_btn_n", 32'(btn_n), 32'(exp_btn_n()));
      end
      check("rand_ovf", 32'(overflow), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
